// File: rtl/segre_pkg.sv
// Shared Segre core types: ID bypass selects plus the hazard-controller scoreboard types.
// Also holds the default M-pipeline latency and the slot-match helper.
package segre_pkg;

    localparam int REG_SIZE          = 5;
    localparam int M_LATENCY_DEFAULT = 5;

    typedef enum logic [1:0] {
        ID_RF,
        EXECUTE_BYPASS,
        MEMORY_BYPASS,
        WRITEBACK_BYPASS
    } bypass_id_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_DRAIN,
        HZ_HALTED
    } hazard_state_e;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [REG_SIZE-1:0] waddr;
        logic                prod_mem;
    } sb_slot_t;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [REG_SIZE-1:0] waddr;
    } m_slot_t;

    // x0 is hard-wired to zero, so a write to it never creates a dependence.
    function automatic logic slot_hit(input logic                rd,
                                      input logic [REG_SIZE-1:0] rs,
                                      input logic                valid,
                                      input logic                we,
                                      input logic [REG_SIZE-1:0] waddr);
        return rd && (rs != '0) && valid && we && (waddr == rs);
    endfunction

endpackage

// File: rtl/segre_src_match.sv
// Per-operand dependence check against the in-flight scoreboard.
// Returns the ID bypass select and the stall-cause bits for one source register.
module segre_src_match
    import segre_pkg::*;
#(
    parameter int M_LATENCY = M_LATENCY_DEFAULT
) (
    input  logic                     rd,
    input  logic [REG_SIZE-1:0]      rs,
    input  sb_slot_t                 ex_slot,
    input  sb_slot_t                 mem_slot,
    input  sb_slot_t                 wb_slot,
    input  m_slot_t [M_LATENCY:1]    m_slots,
    output bypass_id_sel_e           sel,
    output logic                     lduse,
    output logic                     mstall
);

    logic m_hit;
    logic unused_prod_mem;

    assign unused_prod_mem = mem_slot.prod_mem ^ wb_slot.prod_mem;

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        sel    = ID_RF;
        lduse  = 1'b0;
        mstall = 1'b0;
        m_hit  = 1'b0;
        for (int j = 1; j <= M_LATENCY; j++) begin
            m_hit = m_hit | slot_hit(rd, rs, m_slots[j].valid, m_slots[j].we, m_slots[j].waddr);
        end

        // Youngest producer wins; a load still in EX has no value to forward yet.
        if (slot_hit(rd, rs, ex_slot.valid, ex_slot.we, ex_slot.waddr)) begin
            if (ex_slot.prod_mem) begin
                lduse = 1'b1;
            end else begin
                sel = EXECUTE_BYPASS;
            end
        end else if (slot_hit(rd, rs, mem_slot.valid, mem_slot.we, mem_slot.waddr)) begin
            sel = MEMORY_BYPASS;
        end else if (slot_hit(rd, rs, wb_slot.valid, wb_slot.we, wb_slot.waddr)) begin
            sel = WRITEBACK_BYPASS;
        end else if (m_hit) begin
            mstall = 1'b1;
        end
    end

endmodule

// File: rtl/segre_hazard_ctrl.sv
// Segre pipeline hazard controller: bypass selects, IF/ID stall control, M issue and drain.
// Optional macro SEGRE_HAZ_PERF_EN adds saturating per-cause stall counters.
module segre_hazard_ctrl
    import segre_pkg::*;
#(
    parameter int M_LATENCY = M_LATENCY_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    input  logic                id_is_m_i,
    input  logic                id_rf_we_i,
    input  logic [REG_SIZE-1:0] id_waddr_i,
    input  logic                id_prod_ex_i,
    input  logic                id_prod_mem_i,
    input  logic [REG_SIZE-1:0] id_rs_a_i,
    input  logic [REG_SIZE-1:0] id_rs_b_i,
    input  logic                id_rd_a_i,
    input  logic                id_rd_b_i,
    input  logic                flush_i,
    input  logic                finish_test_i,
    output bypass_id_sel_e      mux_sel_a_id_o,
    output bypass_id_sel_e      mux_sel_b_id_o,
    output logic                block_if_o,
    output logic                block_id_o,
    output logic                inject_nops_o,
    output logic                issue_m_o,
    output logic                halted_o
`ifdef SEGRE_HAZ_PERF_EN
    ,
    output logic [31:0]         perf_lduse_o,
    output logic [31:0]         perf_mstall_o,
    output logic [31:0]         perf_wbstall_o
`endif
);

    sb_slot_t              ex_q, mem_q, wb_q, ex_d;
    m_slot_t [M_LATENCY:1] m_q;
    m_slot_t               m1_d;
    hazard_state_e         state_q, state_d;

    logic lduse_a, lduse_b, mstall_a, mstall_b;
    logic lduse, mstall, wb_conflict, stall, advance, running, m_busy, pipe_empty;
    logic unused_prod_ex;

    // Producing at end of EX is already implied by prod_mem being clear.
    assign unused_prod_ex = id_prod_ex_i;

    segre_src_match #(.M_LATENCY(M_LATENCY)) u_match_a (
        .rd      (id_rd_a_i),
        .rs      (id_rs_a_i),
        .ex_slot (ex_q),
        .mem_slot(mem_q),
        .wb_slot (wb_q),
        .m_slots (m_q),
        .sel     (mux_sel_a_id_o),
        .lduse   (lduse_a),
        .mstall  (mstall_a)
    );

    segre_src_match #(.M_LATENCY(M_LATENCY)) u_match_b (
        .rd      (id_rd_b_i),
        .rs      (id_rs_b_i),
        .ex_slot (ex_q),
        .mem_slot(mem_q),
        .wb_slot (wb_q),
        .m_slots (m_q),
        .sel     (mux_sel_b_id_o),
        .lduse   (lduse_b),
        .mstall  (mstall_b)
    );

    // An M op in M[L-3] writes the RF in the same cycle a main-pipe op leaving ID now would.
    assign lduse       = lduse_a | lduse_b;
    assign mstall      = mstall_a | mstall_b;
    assign wb_conflict = !id_is_m_i && id_rf_we_i && m_q[M_LATENCY-3].valid && m_q[M_LATENCY-3].we;
    assign stall       = id_valid_i && (lduse || mstall || wb_conflict);
    assign running     = (state_q == HZ_RUN);
    assign advance     = running && id_valid_i && !stall && !flush_i;
    assign issue_m_o   = advance && id_is_m_i;
    assign halted_o    = (state_q == HZ_HALTED);

    always_comb begin
        m_busy = 1'b0;
        for (int j = 1; j <= M_LATENCY; j++) begin
            m_busy = m_busy | m_q[j].valid;
        end
    end

    assign pipe_empty = !ex_q.valid && !mem_q.valid && !wb_q.valid && !m_busy;

    always_comb begin
        ex_d = '0;
        m1_d = '0;
        if (advance && !id_is_m_i) begin
            ex_d = '{valid: 1'b1, we: id_rf_we_i, waddr: id_waddr_i, prod_mem: id_prod_mem_i};
        end
        if (issue_m_o) begin
            m1_d = '{valid: 1'b1, we: id_rf_we_i, waddr: id_waddr_i};
        end
    end

    always_comb begin
        state_d       = state_q;
        block_if_o    = 1'b0;
        block_id_o    = 1'b0;
        inject_nops_o = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (flush_i) begin
                    inject_nops_o = 1'b1;
                end else if (stall) begin
                    block_if_o    = 1'b1;
                    block_id_o    = 1'b1;
                    inject_nops_o = 1'b1;
                end
                if (advance && finish_test_i) begin
                    state_d = HZ_DRAIN;
                end
            end
            HZ_DRAIN: begin
                block_if_o    = 1'b1;
                block_id_o    = 1'b1;
                inject_nops_o = 1'b1;
                if (pipe_empty) begin
                    state_d = HZ_HALTED;
                end
            end
            default: begin
                block_if_o    = 1'b1;
                block_id_o    = 1'b1;
                inject_nops_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= HZ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: non-blocking updates let every slot sample its neighbour's pre-edge value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            m_q   <= '0;
        end else begin
            wb_q   <= mem_q;
            mem_q  <= ex_q;
            ex_q   <= ex_d;
            m_q[1] <= m1_d;
            for (int j = 2; j <= M_LATENCY; j++) begin
                m_q[j] <= m_q[j-1];
            end
        end
    end

`ifdef SEGRE_HAZ_PERF_EN
    logic [31:0] perf_lduse_q, perf_mstall_q, perf_wbstall_q;

    // Each stalled cycle is charged to one cause only: load-use, then M, then WB port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_lduse_q   <= '0;
            perf_mstall_q  <= '0;
            perf_wbstall_q <= '0;
        end else if (!halted_o && stall && !flush_i) begin
            if (lduse) begin
                if (perf_lduse_q != '1) perf_lduse_q <= perf_lduse_q + 32'd1;
            end else if (mstall) begin
                if (perf_mstall_q != '1) perf_mstall_q <= perf_mstall_q + 32'd1;
            end else begin
                if (perf_wbstall_q != '1) perf_wbstall_q <= perf_wbstall_q + 32'd1;
            end
        end
    end

    assign perf_lduse_o   = perf_lduse_q;
    assign perf_mstall_o  = perf_mstall_q;
    assign perf_wbstall_o = perf_wbstall_q;
`endif

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// Directed bench for segre_hazard_ctrl: expected outputs are queued as each cycle is driven
// and compared on the following falling edge.
module tb_segre_hazard_ctrl;
    import segre_pkg::*;

    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_ISS   = 5'b00010;
    localparam logic [4:0] C_STALL = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00100;
    localparam logic [4:0] C_DRAIN = 5'b10100;
    localparam logic [4:0] C_HALT  = 5'b10101;
    localparam logic [4:0] M_ALL   = 5'b11111;
    localparam logic [4:0] M_DRN   = 5'b10111;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                id_valid_i, id_is_m_i, id_rf_we_i, id_prod_ex_i, id_prod_mem_i;
    logic [REG_SIZE-1:0] id_waddr_i, id_rs_a_i, id_rs_b_i;
    logic                id_rd_a_i, id_rd_b_i, flush_i, finish_test_i;
    bypass_id_sel_e      mux_sel_a_id_o, mux_sel_b_id_o;
    logic                block_if_o, block_id_o, inject_nops_o, issue_m_o, halted_o;
`ifdef SEGRE_HAZ_PERF_EN
    logic [31:0]         perf_lduse_o, perf_mstall_o, perf_wbstall_o;
`endif

    typedef struct {
        string          tag;
        logic [1:0]     care;
        bypass_id_sel_e sel_a;
        bypass_id_sel_e sel_b;
        logic [4:0]     ctl;
        logic [4:0]     mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [4:0] ctl_now;

    assign ctl_now = {block_if_o, block_id_o, inject_nops_o, issue_m_o, halted_o};

    always #5 clk_i = ~clk_i;

    segre_hazard_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_is_m_i     (id_is_m_i),
        .id_rf_we_i    (id_rf_we_i),
        .id_waddr_i    (id_waddr_i),
        .id_prod_ex_i  (id_prod_ex_i),
        .id_prod_mem_i (id_prod_mem_i),
        .id_rs_a_i     (id_rs_a_i),
        .id_rs_b_i     (id_rs_b_i),
        .id_rd_a_i     (id_rd_a_i),
        .id_rd_b_i     (id_rd_b_i),
        .flush_i       (flush_i),
        .finish_test_i (finish_test_i),
        .mux_sel_a_id_o(mux_sel_a_id_o),
        .mux_sel_b_id_o(mux_sel_b_id_o),
        .block_if_o    (block_if_o),
        .block_id_o    (block_id_o),
        .inject_nops_o (inject_nops_o),
        .issue_m_o     (issue_m_o),
        .halted_o      (halted_o)
`ifdef SEGRE_HAZ_PERF_EN
        ,
        .perf_lduse_o  (perf_lduse_o),
        .perf_mstall_o (perf_mstall_o),
        .perf_wbstall_o(perf_wbstall_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.care[1]) check({mon_e.tag, ".sel_a"}, 32'(mux_sel_a_id_o), 32'(mon_e.sel_a));
            if (mon_e.care[0]) check({mon_e.tag, ".sel_b"}, 32'(mux_sel_b_id_o), 32'(mon_e.sel_b));
            check({mon_e.tag, ".ctl"}, 32'(ctl_now & mon_e.mask), 32'(mon_e.ctl & mon_e.mask));
        end
    end

    task automatic idle();
        id_valid_i    = 1'b0;
        id_is_m_i     = 1'b0;
        id_rf_we_i    = 1'b0;
        id_waddr_i    = '0;
        id_prod_ex_i  = 1'b0;
        id_prod_mem_i = 1'b0;
        id_rs_a_i     = '0;
        id_rs_b_i     = '0;
        id_rd_a_i     = 1'b0;
        id_rd_b_i     = 1'b0;
        flush_i       = 1'b0;
        finish_test_i = 1'b0;
    endtask

    task automatic instr(input logic is_m, input logic we, input logic [4:0] wa, input logic pm,
                         input logic ra, input logic [4:0] rsa, input logic rb, input logic [4:0] rsb);
        idle();
        id_valid_i    = 1'b1;
        id_is_m_i     = is_m;
        id_rf_we_i    = we;
        id_waddr_i    = wa;
        id_prod_mem_i = pm;
        id_prod_ex_i  = !pm && !is_m;
        id_rd_a_i     = ra;
        id_rs_a_i     = rsa;
        id_rd_b_i     = rb;
        id_rs_b_i     = rsb;
    endtask

    // Queue this cycle's expectation, then move to just after the next rising edge.
    task automatic step(input string tag, input logic [1:0] care, input bypass_id_sel_e ea,
                        input bypass_id_sel_e eb, input logic [4:0] ctl, input logic [4:0] mask);
        exp_t e;
        e.tag   = tag;
        e.care  = care;
        e.sel_a = ea;
        e.sel_b = eb;
        e.ctl   = ctl;
        e.mask  = mask;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) step("idle", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        @(posedge clk_i);
        #1;
        step("reset", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        rst_i = 1'b0;

        // EX / MEM / WB forwarding, rs=0 and rd gating, youngest-first priority
        instr(0, 1, 5, 0, 1, 0, 0, 0);  step("addi_x5", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 1, 6, 0, 1, 5, 1, 0);  step("ex_byp", 2'b11, EXECUTE_BYPASS, ID_RF, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 1, 5, 1, 6);  step("mem_ex", 2'b11, MEMORY_BYPASS, EXECUTE_BYPASS, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 1, 6, 1, 5);  step("mem_wb", 2'b11, MEMORY_BYPASS, WRITEBACK_BYPASS, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 1, 5, 0, 6);  step("rf_rdoff", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 1, 8, 0, 0, 0, 0, 0);  step("x8_old", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 1, 8, 0, 0, 0, 0, 0);  step("x8_new", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 1, 0, 0, 1, 8, 0, 0);  step("youngest", 2'b11, EXECUTE_BYPASS, ID_RF, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 1, 0, 1, 8);  step("x0_mem", 2'b11, ID_RF, MEMORY_BYPASS, C_NONE, M_ALL);
        idle_cycles(3);

        // Load-use: one stall, then MEM forwarding; then a flush over a load-use stall
        instr(0, 1, 7, 1, 1, 0, 0, 0);  step("lw_x7", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 0, 0, 1, 7);  step("lduse", 2'b00, ID_RF, ID_RF, C_STALL, M_ALL);
        step("lduse_byp", 2'b11, ID_RF, MEMORY_BYPASS, C_NONE, M_ALL);
        instr(0, 1, 7, 1, 0, 0, 0, 0);  step("lw2_x7", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 1, 10, 0, 0, 0, 1, 7);
        flush_i = 1'b1;                 step("flush", 2'b00, ID_RF, ID_RF, C_FLUSH, M_ALL);
        instr(0, 0, 0, 0, 1, 10, 1, 7); step("post_flush", 2'b11, ID_RF, MEMORY_BYPASS, C_NONE, M_ALL);
        idle_cycles(3);

        // M dependence: stall while the MUL sits in M1..M5
        instr(1, 1, 3, 0, 0, 0, 0, 0);  step("mul_x3", 2'b11, ID_RF, ID_RF, C_ISS, M_ALL);
        instr(0, 1, 11, 0, 1, 3, 0, 0);
        for (int i = 1; i <= 5; i++) step($sformatf("mdep%0d", i), 2'b00, ID_RF, ID_RF, C_STALL, M_ALL);
        step("mdep_clear", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        idle_cycles(3);

        // Write-port conflict with M[L-3], and its non-triggering neighbours
        instr(1, 1, 4, 0, 0, 0, 0, 0);  step("mul_x4", 2'b11, ID_RF, ID_RF, C_ISS, M_ALL);
        idle();                         step("gap", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 1, 9, 0, 0, 0, 0, 0);  step("wbport", 2'b11, ID_RF, ID_RF, C_STALL, M_ALL);
        step("wbport_go", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(1, 1, 13, 0, 0, 0, 0, 0); step("mul_x13", 2'b11, ID_RF, ID_RF, C_ISS, M_ALL);
        instr(0, 1, 9, 0, 0, 0, 0, 0);  step("wb_m1", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 0, 9, 0, 0, 0, 0, 0);  step("wb_nowe", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        idle_cycles(6);

        // Finish with a MUL in M2: four drain cycles, then halted
        instr(1, 1, 3, 0, 0, 0, 0, 0);  step("mul_fin", 2'b11, ID_RF, ID_RF, C_ISS, M_ALL);
        idle();                         step("gap2", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        finish_test_i = 1'b1;           step("finish", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        idle();
        for (int i = 1; i <= 4; i++) step($sformatf("drain%0d", i), 2'b00, ID_RF, ID_RF, C_DRAIN, M_DRN);
        step("halted", 2'b00, ID_RF, ID_RF, C_HALT, M_DRN);
        step("halt_hold", 2'b00, ID_RF, ID_RF, C_HALT, M_DRN);
        rst_i = 1'b1;
        #1;
        check("rst_halt.ctl", 32'(ctl_now), 32'(C_NONE));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset while draining clears everything at once, including the in-flight MUL
        instr(1, 1, 3, 0, 0, 0, 0, 0);  step("mul_g", 2'b11, ID_RF, ID_RF, C_ISS, M_ALL);
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        finish_test_i = 1'b1;           step("finish_g", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        idle();                         step("drain_g", 2'b00, ID_RF, ID_RF, C_DRAIN, M_DRN);
        rst_i = 1'b1;
        #1;
        check("rst_drain.ctl", 32'(ctl_now), 32'(C_NONE));
        check("rst_drain.sel_a", 32'(mux_sel_a_id_o), 32'(ID_RF));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        instr(0, 1, 5, 0, 1, 3, 0, 0);  step("after_rst", 2'b11, ID_RF, ID_RF, C_NONE, M_ALL);
        instr(0, 0, 0, 0, 0, 0, 1, 5);  step("after_rst_ex", 2'b11, ID_RF, EXECUTE_BYPASS, C_NONE, M_ALL);
        idle();

        @(negedge clk_i);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
